// File: rtl/shift_rows_stage.sv
// AES ShiftRows / InvShiftRows pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// The transform is applied on the input side so both holding registers store finished beats.
module shift_rows_stage #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             enc_or_dec_i,
    input  logic [127:0]     in_state_i,
    input  logic [TAG_W-1:0] in_round_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [127:0]     out_state_o,
    output logic [TAG_W-1:0] out_round_o,
    output logic             out_last_o,
    output logic [CNT_W-1:0] beat_cnt_o
);

    typedef struct packed {
        logic [127:0]     state;
        logic [TAG_W-1:0] round;
        logic             last;
    } beat_t;

    beat_t            in_beat, main_q, skid_q;
    logic             main_valid, skid_valid;
    logic [127:0]     shifted;
    logic [CNT_W-1:0] beat_cnt_q;
    logic             in_xfer, out_xfer;

    // Byte (r,c) sits at bits [127-32c-8r -: 8]; each output byte picks its source column per direction.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int ENC_C = (c + r) % 4;
            localparam int DEC_C = (c - r + 4) % 4;
            assign shifted[127-32*c-8*r -: 8] = enc_or_dec_i ? in_state_i[127-32*ENC_C-8*r -: 8]
                                                             : in_state_i[127-32*DEC_C-8*r -: 8];
        end
    end

    assign in_beat  = {shifted, in_round_i, in_last_i};
    assign in_xfer  = in_valid_i & in_ready_o;
    assign out_xfer = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            if (out_xfer && skid_valid) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end else if (in_xfer && (!main_valid || out_xfer)) begin
                main_q     <= in_beat;
                main_valid <= 1'b1;
            end else if (in_xfer) begin
                skid_q     <= in_beat;
                skid_valid <= 1'b1;
            end else if (out_xfer) begin
                main_valid <= 1'b0;
            end
            if (out_xfer && beat_cnt_q != {CNT_W{1'b1}})
                beat_cnt_q <= beat_cnt_q + 1'b1;
        end
    end

    // Ready depends only on the skid flop, so no combinational path from out_ready_i.
    assign in_ready_o  = ~skid_valid;
    assign out_valid_o = main_valid;
    assign out_state_o = main_q.state;
    assign out_round_o = main_q.round;
    assign out_last_o  = main_q.last;
    assign beat_cnt_o  = beat_cnt_q;

endmodule

// File: tb/tb_shift_rows_stage.sv
// Scoreboard bench for shift_rows_stage; a second instance with a 4-bit counter covers saturation.
module tb_shift_rows_stage;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         enc = 1'b1;
    logic [127:0] in_state = '0;
    logic [3:0]   in_round = '0;
    logic         in_last = 1'b0;
    logic         out_ready = 1'b0;

    logic         in_ready, out_valid, out_last;
    logic [127:0] out_state;
    logic [3:0]   out_round;
    logic [15:0]  cnt;
    logic         in_ready4, out_valid4, out_last4;
    logic [127:0] out_state4;
    logic [3:0]   out_round4;
    logic [3:0]   cnt4;

    always #5 clk = ~clk;

    shift_rows_stage #(.TAG_W(4), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .enc_or_dec_i(enc), .in_state_i(in_state), .in_round_i(in_round), .in_last_i(in_last),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_state_o(out_state),
        .out_round_o(out_round), .out_last_o(out_last), .beat_cnt_o(cnt)
    );

    shift_rows_stage #(.TAG_W(4), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready4),
        .enc_or_dec_i(enc), .in_state_i(in_state), .in_round_i(in_round), .in_last_i(in_last),
        .out_valid_o(out_valid4), .out_ready_i(out_ready), .out_state_o(out_state4),
        .out_round_o(out_round4), .out_last_o(out_last4), .beat_cnt_o(cnt4)
    );

    typedef struct {
        logic [127:0] st;
        logic [3:0]   rnd;
        logic         last;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] drv_exp = '0;
    logic         acc = 1'b0;
    int           total = 0;
    int           bad = 0;
    int           pops = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] sr_ref(input logic [127:0] s, input logic e);
        logic [7:0]   b[4][4];
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r][c] = s[127-32*c-8*r -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-32*c-8*r -: 8] = e ? b[r][(c + r) % 4] : b[r][(c + 4 - r) % 4];
        return o;
    endfunction

    // Inputs are stable by the falling edge; handshakes seen there are the ones the next rising edge takes.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        acc = 1'b0;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("out_state", out_state, e.st);
                    chk("out_round", out_round, e.rnd);
                    chk("out_last", out_last, e.last);
                    pops++;
                end
            end
            acc = in_valid && in_ready;
            if (acc) sb.push_back('{drv_exp, in_round, in_last});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic send(input logic [127:0] st, input logic e, input logic [3:0] rnd,
                        input logic lst, input logic [127:0] ex);
        int n;
        in_state = st; enc = e; in_round = rnd; in_last = lst; drv_exp = ex;
        in_valid = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            cycle();
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic stream20();
        logic [127:0] s;
        int p0;
        p0 = pops;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            in_state = s; enc = (i % 2 == 0); in_round = 4'(i % 10); in_last = (i % 3 == 0);
            drv_exp = sr_ref(s, enc);
            in_valid = 1'b1;
            cycle();
            chk("stream_rdy", acc, 1);
            chk("stream_ov", out_valid, 1);
        end
        drain();
        chk("stream_count", pops - p0, 20);
    endtask

    initial begin
        do_reset();
        chk("rst_ov", out_valid, 0);
        chk("rst_rdy", in_ready, 1);
        chk("rst_state", out_state, 0);
        chk("rst_cnt", cnt, 0);

        // FIPS-197 round 1, encrypt; held to observe 1-cycle latency.
        out_ready = 1'b0;
        send(128'hd42711aee0bf98f1b8b45de51e415230, 1, 1, 0, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        chk("fips_ov", out_valid, 1);
        chk("fips_state", out_state, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        chk("fips_round", out_round, 1);
        drain();
        send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 0, 2, 1, 128'hd42711aee0bf98f1b8b45de51e415230);
        send(128'h000102030405060708090a0b0c0d0e0f, 1, 3, 0, 128'h00050a0f04090e03080d02070c01060b);
        send(128'h000102030405060708090a0b0c0d0e0f, 0, 4, 0, 128'h000d0a0704010e0b0805020f0c090603);
        drain();

        // Back-pressure: two beats fill main and skid, third must wait.
        do_reset();
        out_ready = 1'b0;
        send(128'h11, 1, 1, 0, sr_ref(128'h11, 1));
        send(128'h22, 0, 2, 0, sr_ref(128'h22, 0));
        chk("bp_full_rdy", in_ready, 0);
        in_state = 128'h33; enc = 1; in_round = 3; in_last = 1; drv_exp = sr_ref(128'h33, 1);
        in_valid = 1'b1;
        cycle();
        cycle();
        chk("bp_wait", acc, 0);
        chk("bp_hold_round", out_round, 1);
        out_ready = 1'b1;
        for (int n = 0; n < 10 && !acc; n++) cycle();
        chk("bp_accept3", acc, 1);
        drain();
        chk("bp_cnt", cnt, 3);

        // Streaming plus counter saturation on the narrow instance.
        do_reset();
        stream20();
        chk("cnt16", cnt, 20);
        chk("cnt4_sat", cnt4, 15);

        // Reset with both registers full.
        out_ready = 1'b0;
        send(128'hab, 1, 5, 0, sr_ref(128'hab, 1));
        send(128'hcd, 0, 6, 1, sr_ref(128'hcd, 0));
        chk("mid_full", in_ready, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sb.delete();
        chk("mid_ov", out_valid, 0);
        chk("mid_rdy", in_ready, 1);
        chk("mid_state", out_state, 0);
        chk("mid_cnt", cnt, 0);
        send(128'h0123456789abcdef0011223344556677, 1, 7, 1,
             sr_ref(128'h0123456789abcdef0011223344556677, 1));
        chk("mid_lat", out_valid, 1);
        drain();
        chk("mid_cnt_after", cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_rows_stage.md
Name: shift_rows_stage

Overview:
- Registered pipeline stage directly downstream of sub_bytes in the AES-128 round datapath.
- Applies ShiftRows (encrypt) or InvShiftRows (decrypt) to the 128-bit state, selected per beat.
- Carries a round tag and a last-round flag alongside each beat.
- Valid/ready handshake with a 2-entry skid buffer, so the round controller and mix_columns can apply back-pressure without combinational ready paths.

Parameters:
- TAG_W, 4: width of the round-number tag carried with each beat.
- CNT_W, 16: width of the saturating output-beat counter.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- in_valid_i  input  1  upstream beat valid.
- in_ready_o  output  1  stage can accept a beat.
- enc_or_dec_i  input  1  1 = ShiftRows (encrypt), 0 = InvShiftRows (decrypt); sampled with the beat.
- in_state_i  input  128  state from sub_bytes.
- in_round_i  input  TAG_W  round tag.
- in_last_i  input  1  final-round flag (mix_columns bypass downstream).
- out_valid_o  output  1  output beat valid.
- out_ready_i  input  1  downstream accepts the beat.
- out_state_o  output  128  shifted state.
- out_round_o  output  TAG_W  tag of the output beat.
- out_last_o  output  1  last flag of the output beat.
- beat_cnt_o  output  CNT_W  count of completed output transfers, saturating.

Behaviour:
- Byte map (same as sub_bytes): column c = bits [127-32c : 96-32c]; row r of column c = bits [127-32c-8r : 120-32c-8r]; state s[r][c].
- Encrypt: out[r][c] = s[r][(c+r) mod 4]. Decrypt: out[r][c] = s[r][(c-r) mod 4]. Row 0 is never moved.
- Transform is combinational on the input side. Both registers hold already-transformed data plus tag and last.
- Registers: main (drives out_*) and skid; each has its own valid bit.
- out_valid_o = main_valid. in_ready_o = ~skid_valid, a pure register output with no combinational path from out_ready_i.
- Input transfer: in_valid_i & in_ready_o. Output transfer: out_valid_o & out_ready_i.
- Latency: 1 cycle. A beat accepted at edge N appears on out_* after edge N when main was empty or draining.
- Update rules per edge, applied in priority order:
  1. Output transfer and skid_valid: main <= skid, skid_valid <= 0. An input transfer cannot occur in this case, since in_ready_o = 0.
  2. Input transfer and (main empty or output transfer): main <= new beat.
  3. Input transfer with main full and no output transfer: skid <= new beat, skid_valid <= 1.
  4. Output transfer with no input transfer and skid empty: main_valid <= 0.
- Simultaneous input and output transfer with skid empty: main is replaced by the new beat in the same edge. Sustains 1 beat/cycle.
- Full (both registers valid): in_ready_o = 0. Upstream holds its beat stable until accepted.
- out_* stay stable while out_valid_o = 1 and out_ready_i = 0.
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- beat_cnt_o increments by 1 on each output transfer and holds at 2^CNT_W-1.
- Reset (rst_i = 1 at an edge):
  - main_valid and skid_valid <= 0; out_state_o, out_round_o, out_last_o, skid contents <= 0; beat_cnt_o <= 0.
  - Inputs are ignored that edge.
  - Reset mid-operation discards buffered beats.
  - After reset: out_valid_o = 0, in_ready_o = 1.
- Data registers load only on the rules above. No X propagation from unused inputs.

Test Plan:
- Encrypt, FIPS-197 App. B round 1: in_state_i = d42711aee0bf98f1b8b45de51e415230, enc = 1, round = 1, last = 0 -> out_state_o = d4bf5d30e0b452aeb84111f11e2798e5, out_round_o = 1, out_last_o = 0, one cycle later.
- Decrypt: in_state_i = d4bf5d30e0b452aeb84111f11e2798e5, enc = 0 -> out_state_o = d42711aee0bf98f1b8b45de51e415230. Also in_state_i = 000102030405060708090a0b0c0d0e0f:
  - enc = 1 -> 00050a0f04090e03080d02070c01060b.
  - enc = 0 -> 000d0a0704010e0b0805020f0c090603.
- Back-pressure: hold out_ready_i = 0 and offer 3 beats (tags 1, 2, 3):
  - After beats 1 and 2 are accepted, in_ready_o = 0 and beat 3 waits.
  - Release out_ready_i -> outputs in order 1, 2, 3, no loss; beat_cnt_o = 3.
- Streaming: in_valid_i and out_ready_i both high for 20 cycles, alternating enc/dec and tags 0..9 repeating -> 20 outputs, one per cycle, correct per-beat transform, in_ready_o constantly 1.
- Reset mid-operation: both registers full, assert rst_i for one edge -> out_valid_o = 0, in_ready_o = 1, out_state_o = 0, beat_cnt_o = 0. A following beat passes with 1-cycle latency.
- Counter saturation, CNT_W = 4: 20 output transfers -> beat_cnt_o stops at 15.
